// File: rtl/truth_table_driver_if.sv
// Stimulus/response bundle between truth_table_driver (master) and the board-side
// DUT or bench (slave).
interface truth_table_driver_if #(
   parameter int unsigned N_IN = 3
);
   logic                  START;
   logic [N_IN-1:0]       STIM;
   logic                  RESP;
   logic                  BUSY;
   logic                  DONE;
   logic                  PASS;
   logic [N_IN:0]         ERR_CNT;
   logic [N_IN-1:0]       FAIL_IDX;
   logic [(2**N_IN)-1:0]  CAPTURE;

   modport master (
      input  START, RESP,
      output STIM, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX, CAPTURE
   );

   modport slave (
      output START, RESP,
      input  STIM, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX, CAPTURE
   );
endinterface

// File: rtl/truth_table_driver.sv
// Sweeps every input vector into a combinational DUT, checks RESP against EXPECT.
// Optional `STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module truth_table_driver #(
   parameter int unsigned          N_IN   = 3,
   parameter int unsigned          SETTLE = 1,
   parameter logic [2**N_IN-1:0]   EXPECT = 8'hF8
) (
   input logic                  CLK,
   input logic                  RST_N,
   truth_table_driver_if.master bus
);

   localparam int unsigned NV = 2**N_IN;
   localparam int unsigned EW = N_IN + 1;
   localparam int unsigned CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [CW-1:0]   SETTLE_C = CW'(SETTLE);
   localparam logic [N_IN-1:0] LAST     = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t          state,    state_n;
   logic [N_IN-1:0] stim,     stim_n;
   logic [CW-1:0]   cnt,      cnt_n;
   logic [EW-1:0]   err_cnt,  err_n;
   logic [N_IN-1:0] fail_idx, fidx_n;
   logic [NV-1:0]   capture,  cap_n;
   logic            pass,     pass_n;
   logic            mismatch;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= S_IDLE;
         stim     <= '0;
         cnt      <= '0;
         err_cnt  <= '0;
         fail_idx <= '0;
         capture  <= '0;
         pass     <= 1'b0;
      end else begin
         state    <= state_n;
         stim     <= stim_n;
         cnt      <= cnt_n;
         err_cnt  <= err_n;
         fail_idx <= fidx_n;
         capture  <= cap_n;
         pass     <= pass_n;
      end
   end

   // stim doubles as the vector index, so STIM stays put through WAIT/SAMPLE.
   always_comb begin
      state_n  = state;
      stim_n   = stim;
      cnt_n    = cnt;
      err_n    = err_cnt;
      fidx_n   = fail_idx;
      cap_n    = capture;
      pass_n   = pass;
      mismatch = 1'b0;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (bus.START) begin
               state_n = S_WAIT;
               stim_n  = '0;
               cnt_n   = SETTLE_C;
               err_n   = '0;
               fidx_n  = '0;
               cap_n   = '0;
               pass_n  = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt == '0) state_n = S_SAMPLE;
            else           cnt_n   = cnt - CW'(1);
         end
         S_SAMPLE: begin
            mismatch    = (bus.RESP != EXPECT[stim]);
            cap_n[stim] = bus.RESP;
            if (mismatch) begin
               err_n = err_cnt + EW'(1);
               if (err_cnt == '0) fidx_n = stim;
            end
`ifdef STOP_ON_FAIL_EN
            if (mismatch) begin
               state_n = S_DONE;
               pass_n  = 1'b0;
            end else
`endif
            if (stim == LAST) begin
               state_n = S_DONE;
               pass_n  = (err_n == '0);
            end else begin
               stim_n  = stim + N_IN'(1);
               cnt_n   = SETTLE_C;
               state_n = S_WAIT;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.STIM     = stim;
   assign bus.BUSY     = (state == S_WAIT) || (state == S_SAMPLE);
   assign bus.DONE     = (state == S_DONE);
   assign bus.PASS     = pass;
   assign bus.ERR_CNT  = err_cnt;
   assign bus.FAIL_IDX = fail_idx;
   assign bus.CAPTURE  = capture;

endmodule

// File: doc/truth_table_driver.md
Name: truth_table_driver

Overview:
- Sequential stimulus generator and response checker for the team's small combinational circuits; the driving end of the `A, B, C -> f1` interface.
- Walks every input combination in order, drives it to the device under test (DUT), and samples the DUT's single output after a settle delay.
- Compares each sample against an expected truth table, captures the observed table, and reports pass/fail, error count and first failing index.
- Sits on the board next to the DUT and replaces manual switch-toggling.

Parameters:
- N_IN, 3, number of DUT inputs; vector count is 2**N_IN.
- SETTLE, 1, extra wait cycles between driving a vector and sampling the response (0 allowed).
- EXPECT, 8'hF8, expected truth table, width 2**N_IN; bit i = expected output for input vector i. Default is f1 = A | (B & C), with {A,B,C} = i.

Ports:
- CLK  in  1  clock, all state changes on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- STIM  out  N_IN  vector driven to the DUT; MSB maps to A, LSB to C.
- RESP  in  1  DUT output (f1).
- BUSY  out  1  high while a sweep is running.
- DONE  out  1  high, held, after the sweep completes, until the next START or reset.
- PASS  out  1  valid when DONE; 1 iff ERR_CNT == 0.
- ERR_CNT  out  N_IN+1  number of mismatching vectors.
- FAIL_IDX  out  N_IN  index of the first mismatch; 0 when none.
- CAPTURE  out  2**N_IN  observed truth table; bit i = RESP sampled for vector i.

Behaviour:
- Reset (RST_N low at a rising edge) forces:
  - state IDLE;
  - STIM, ERR_CNT, FAIL_IDX, CAPTURE = 0;
  - BUSY, DONE, PASS = 0.
- Reset asserted mid-sweep aborts the sweep immediately, with the same values as above.
- FSM states are IDLE, WAIT, SAMPLE, DONE.
- IDLE or DONE + START:
  - idx = 0, STIM = 0, cnt = SETTLE;
  - ERR_CNT, FAIL_IDX, CAPTURE cleared; DONE = 0, PASS = 0, BUSY = 1;
  - next state WAIT.
- WAIT: if cnt == 0 then go to SAMPLE, else cnt decrements.
- SAMPLE:
  - CAPTURE[idx] = RESP.
  - If RESP != EXPECT[idx], ERR_CNT increments; if ERR_CNT was 0, FAIL_IDX = idx.
  - If idx == 2**N_IN - 1: go to DONE, BUSY = 0, DONE = 1, PASS = (final ERR_CNT == 0).
  - Otherwise: idx increments, STIM = idx + 1, cnt = SETTLE, go to WAIT.
- Per-vector cost is SETTLE + 2 cycles. Sweep length is 2**N_IN * (SETTLE + 2) cycles from the START edge to the DONE rising edge; defaults give 24.
- STIM is stable for the whole WAIT/SAMPLE window of each vector. RESP is sampled on the SAMPLE-state edge only.
- START while BUSY is ignored, with no effect on any output.
- START held high across DONE restarts a new sweep on the next edge.
- ERR_CNT is sized so that all-fail (2**N_IN) does not overflow; no saturation logic is needed.
- Last vector: no increment beyond 2**N_IN - 1. STIM holds its final vector in DONE.

Optional Feature:
- Macro: STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE ends the sweep immediately.
  - Next state DONE, PASS = 0, ERR_CNT = 1, FAIL_IDX = idx.
  - CAPTURE bits above idx remain 0. STIM holds the failing vector.
- Undefined: the full sweep always runs, as described under Behaviour.

Test Plan:
- Golden DUT model RESP = A|(B&C), defaults, START pulse:
  - STIM steps 0..7, each vector held 3 cycles;
  - DONE at cycle 24, PASS = 1, ERR_CNT = 0, FAIL_IDX = 0, CAPTURE = 8'hF8.
- RESP stuck at 0:
  - ERR_CNT = 5, FAIL_IDX = 3, CAPTURE = 8'h00, PASS = 0.
- RESP = ~golden:
  - ERR_CNT = 8, FAIL_IDX = 0, CAPTURE = 8'h07, PASS = 0.
- START pulsed at cycles 5 and 10 during a sweep:
  - both ignored, DONE still at cycle 24.
  - A second START in DONE clears DONE/ERR_CNT/CAPTURE next cycle and reruns: DONE again 24 cycles later.
- RST_N low for 1 cycle at cycle 10 mid-sweep:
  - next cycle all outputs 0, state IDLE.
  - Subsequent START runs a clean full sweep.
- STOP_ON_FAIL_EN defined, RESP stuck at 0:
  - DONE at cycle 12, ERR_CNT = 1, FAIL_IDX = 3, STIM = 3, CAPTURE = 8'h00.
  - Same stimulus with the macro undefined matches the stuck-at-0 scenario above.
